t01_drop_ctrl: RTL and testbench
================================

Name: t01_drop_ctrl

Overview:
Gravity sequencer for the falling piece; sits directly downstream of the 1 Hz/score-scaled drop-tick divider and consumes its active-low one-cycle tick.
Each tick asks the collision checker whether the piece can move down one row.
It advances the piece row on a clear result and applies a lock delay on a blocked result, then issues a one-cycle lock pulse to the board-commit logic.
Hard drop bypasses the tick and the lock delay.

Parameters:
ROW_W, 5, width of piece row counter
MAX_ROW, 19, bottom row index; piece at MAX_ROW is treated as blocked without a checker request
LOCK_TICKS, 2, blocked check results needed to lock (legal range 1..15)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  game running; low pauses gravity
spawn  input  1  one-cycle pulse: new piece placed at row 0
drop_tick_n  input  1  active-low one-cycle drop strobe from divider
hard_drop  input  1  one-cycle pulse: drop piece to floor immediately
chk_req  output  1  request collision check for row+1; held until chk_ack
chk_ack  input  1  checker response valid (one cycle)
chk_blocked  input  1  valid with chk_ack: 1 = cannot move down
row  output  ROW_W  current piece row
active  output  1  piece in play (state != IDLE)
lock  output  1  one-cycle pulse: commit piece at row

Behaviour:
- Clocking: single clk. rst is synchronous, active-high, and overrides everything.
- Reset values: state=IDLE, row=0, chk_req=0, lock=0, active=0, lock_cnt=0, hd=0.
- A tick is drop_tick_n sampled 0 at a clk edge. The divider emits one spurious tick after its own reset; it is harmless because IDLE ignores ticks.
- IDLE:
  - spawn -> FALL with row=0, lock_cnt=0, hd=0.
  - Ticks and hard_drop are ignored.
  - spawn and a tick in the same cycle: spawn taken, tick dropped.
- FALL:
  - hard_drop sets hd=1.
  - Check path: if hd=1, or en=1 and a tick arrives:
    - row==MAX_ROW -> internal blocked result (no request); apply the blocked rule below.
    - otherwise -> CHECK.
- CHECK:
  - chk_req=1, registered, asserted from the first CHECK cycle. Held until chk_ack is sampled, and dropped the cycle after.
  - CHECK always completes regardless of en.
  - Ticks during CHECK are discarded, not queued. hard_drop during CHECK sets hd.
- On chk_ack with chk_blocked=0: row<=row+1, lock_cnt<=0, -> FALL.
- Blocked rule:
  - If hd=1 -> COMMIT.
  - Otherwise lock_cnt<=lock_cnt+1.
    - lock_cnt+1==LOCK_TICKS -> COMMIT.
    - else -> LOCKWAIT.
- LOCKWAIT:
  - Paused while en=0.
  - hard_drop -> hd=1, then CHECK immediately (or internal blocked if row==MAX_ROW).
  - Tick -> CHECK (or internal blocked if row==MAX_ROW).
  - A clear result returns to FALL and clears lock_cnt (piece slid off a ledge).
- COMMIT: lock=1 for exactly one cycle, row held, -> IDLE next cycle. row keeps its value in IDLE until the next spawn.
- Hard-drop latency: with zero-wait ack, one row per 2 cycles. Ticks are irrelevant while hd=1.
- Row arithmetic:
  - row never exceeds MAX_ROW; no wrap.
  - chk_ack with chk_blocked=0 at row==MAX_ROW cannot occur, because no request is issued at MAX_ROW.
- Stray inputs: chk_ack outside CHECK is ignored. spawn outside IDLE is ignored.
- rst mid-CHECK deasserts chk_req at that edge. The checker must tolerate an abandoned request.

Test Plan:
- Reset mid-CHECK -> next cycle chk_req=0, active=0, row=0. Also: tick pulse with no spawn -> state stays IDLE, chk_req never rises.
- spawn, then 3 ticks each answered (ack, blocked=0) after 2 wait cycles -> row=3, chk_req high exactly 3 cycles per request, no lock.
- Default LOCK_TICKS=2 at row=7:
  - blocked tick -> LOCKWAIT, no lock; second blocked tick -> lock pulse, row=7, active=0 next cycle.
  - Variant: second check clear -> row=8, lock_cnt=0.
- hard_drop at row=2 with zero-wait clear acks until a blocked ack at row=10 -> row=10, single lock pulse, no tick needed.
- Piece driven to row=MAX_ROW=19 -> next tick produces no chk_req. LOCK_TICKS=2 gives lock on the second such tick. row stays 19.
- Pause and dropped ticks:
  - en=0 in FALL with ticks -> no requests, row unchanged.
  - en=0 during an outstanding CHECK -> the ack is still consumed.
  - Tick arriving during CHECK -> no second request afterward.

Source files
------------

// File: rtl/t01_drop_ctrl.sv
// rtl/t01_drop_ctrl.sv - gravity sequencer: tick-driven row advance, lock delay, hard drop
module t01_drop_ctrl #(
    parameter int ROW_W      = 5,
    parameter int MAX_ROW    = 19,
    parameter int LOCK_TICKS = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             spawn_i,
    input  logic             drop_tick_n_i,
    input  logic             hard_drop_i,
    output logic             chk_req_o,
    input  logic             chk_ack_i,
    input  logic             chk_blocked_i,
    output logic [ROW_W-1:0] row_o,
    output logic             active_o,
    output logic             lock_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FALL,
        S_CHECK,
        S_LOCKWAIT,
        S_COMMIT
    } state_e;

    localparam logic [ROW_W-1:0] MAX_ROW_L = ROW_W'(MAX_ROW);
    localparam logic [3:0]       LOCK_L    = 4'(LOCK_TICKS);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [3:0]       lock_cnt_q, lock_cnt_d;
    logic             hd_q, hd_d;
    logic             chk_req_q;
    logic             lock_q;

    logic             tick;
    logic             go;
    logic             blocked_res;
    logic [3:0]       lock_cnt_inc;

    assign tick         = ~drop_tick_n_i;
    assign lock_cnt_inc = lock_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        lock_cnt_d  = lock_cnt_q;
        hd_d        = hd_q;
        go          = 1'b0;
        blocked_res = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (spawn_i) begin
                    state_d    = S_FALL;
                    row_d      = '0;
                    lock_cnt_d = '0;
                    hd_d       = 1'b0;
                end
            end
            S_FALL: begin
                if (hard_drop_i) begin
                    hd_d = 1'b1;
                end
                go = hd_q | hard_drop_i | (en_i & tick);
            end
            S_CHECK: begin
                if (hard_drop_i) begin
                    hd_d = 1'b1;
                end
                if (chk_ack_i) begin
                    if (chk_blocked_i) begin
                        blocked_res = 1'b1;
                    end else begin
                        row_d      = row_q + ROW_W'(1);
                        lock_cnt_d = '0;
                        state_d    = S_FALL;
                    end
                end
            end
            S_LOCKWAIT: begin
                // Everything, including hard drop, is frozen while paused.
                if (en_i) begin
                    if (hard_drop_i) begin
                        hd_d = 1'b1;
                    end
                    go = hd_q | hard_drop_i | tick;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // At the floor no request is made; the result is known to be blocked.
        if (go) begin
            if (row_q == MAX_ROW_L) begin
                blocked_res = 1'b1;
            end else begin
                state_d = S_CHECK;
            end
        end

        if (blocked_res) begin
            if (hd_d) begin
                state_d = S_COMMIT;
            end else begin
                lock_cnt_d = lock_cnt_inc;
                state_d    = (lock_cnt_inc == LOCK_L) ? S_COMMIT : S_LOCKWAIT;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            lock_cnt_q <= '0;
            hd_q       <= 1'b0;
            chk_req_q  <= 1'b0;
            lock_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            lock_cnt_q <= lock_cnt_d;
            hd_q       <= hd_d;
            chk_req_q  <= (state_d == S_CHECK);
            lock_q     <= (state_d == S_COMMIT);
        end
    end

    assign chk_req_o = chk_req_q;
    assign row_o     = row_q;
    assign active_o  = (state_q != S_IDLE);
    assign lock_o    = lock_q;

endmodule

// File: tb/tb_t01_drop_ctrl.sv
// tb/tb_t01_drop_ctrl.sv - directed bench for t01_drop_ctrl with per-cycle behavioural model
module tb_t01_drop_ctrl;

    localparam int MAX_ROW    = 19;
    localparam int LOCK_TICKS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       spawn = 1'b0;
    logic       tick_n = 1'b1;
    logic       hard_drop = 1'b0;
    logic       chk_ack = 1'b0;
    logic       chk_blocked = 1'b0;
    logic       chk_req;
    logic       active;
    logic       lock;
    logic [4:0] row;

    int checks = 0;
    int errors = 0;

    // piece model: in play, asking checker, resting on a ledge, locking
    bit m_play, m_ask, m_rest, m_lock, m_hd;
    int m_row, m_strikes;

    // environment: checker responder and observation counters
    int  r_wait = 0;
    int  rcnt = 0;
    int  blk_row = 31;
    int  lock_seen = 0;
    int  req_rises = 0;
    bit  prev_req = 1'b0;

    always #5 clk = ~clk;

    t01_drop_ctrl #(
        .ROW_W(5),
        .MAX_ROW(MAX_ROW),
        .LOCK_TICKS(LOCK_TICKS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .en_i(en),
        .spawn_i(spawn),
        .drop_tick_n_i(tick_n),
        .hard_drop_i(hard_drop),
        .chk_req_o(chk_req),
        .chk_ack_i(chk_ack),
        .chk_blocked_i(chk_blocked),
        .row_o(row),
        .active_o(active),
        .lock_o(lock)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic piece_blocked();
        if (m_hd) begin
            m_lock = 1'b1;
            m_rest = 1'b0;
        end else begin
            m_strikes++;
            if (m_strikes == LOCK_TICKS) begin
                m_lock = 1'b1;
                m_rest = 1'b0;
            end else begin
                m_rest = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        bit tk;
        bit go;
        tk = !tick_n;
        go = 1'b0;
        if (rst) begin
            m_play = 0; m_ask = 0; m_rest = 0; m_lock = 0; m_hd = 0;
            m_row = 0; m_strikes = 0;
        end else if (m_lock) begin
            m_lock = 0;
            m_play = 0;
        end else if (!m_play) begin
            if (spawn) begin
                m_play = 1; m_row = 0; m_strikes = 0; m_hd = 0; m_rest = 0;
            end
        end else if (m_ask) begin
            if (hard_drop) m_hd = 1;
            if (chk_ack) begin
                m_ask = 0;
                if (chk_blocked) begin
                    piece_blocked();
                end else begin
                    m_row++;
                    m_strikes = 0;
                    m_rest = 0;
                end
            end
        end else begin
            if (m_rest) go = en && (hard_drop || tk);
            else        go = m_hd || hard_drop || (en && tk);
            if (hard_drop && (!m_rest || en)) m_hd = 1;
            if (go) begin
                if (m_row == MAX_ROW) begin
                    piece_blocked();
                end else begin
                    m_ask = 1;
                    m_rest = 0;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        chk("chk_req", int'(chk_req), int'(m_ask));
        chk("row", int'(row), m_row);
        chk("active", int'(active), int'(m_play));
        chk("lock", int'(lock), int'(m_lock));
    end

    task automatic cyc();
        @(negedge clk);
        #1;
        if (lock) lock_seen++;
        if (chk_req && !prev_req) req_rises++;
        prev_req = chk_req;
        spawn = 0;
        hard_drop = 0;
        tick_n = 1;
        chk_ack = 0;
        chk_blocked = 0;
        if (chk_req) begin
            if (rcnt == r_wait) begin
                chk_ack = 1;
                chk_blocked = (int'(row) >= blk_row);
                rcnt = 0;
            end else begin
                rcnt++;
            end
        end else begin
            rcnt = 0;
        end
    endtask

    task automatic tick_wait(output int hi);
        tick_n = 0;
        cyc();
        hi = 0;
        for (int i = 0; i < 40 && chk_req; i++) begin
            hi++;
            cyc();
        end
    endtask

    task automatic do_spawn();
        spawn = 1;
        cyc();
    endtask

    initial begin
        int hi;
        int base;
        int lat;
        int rises0;

        @(negedge clk);
        rst = 1;
        cyc();
        cyc();
        rst = 0;
        chk("rst_active", int'(active), 0);
        chk("rst_row", int'(row), 0);
        chk("rst_req", int'(chk_req), 0);
        chk("rst_lock", int'(lock), 0);

        // spurious tick while idle
        tick_n = 0;
        cyc(); cyc(); cyc();
        chk("idle_tick_rises", req_rises, 0);
        chk("idle_tick_active", int'(active), 0);

        // three clear steps, two wait cycles each
        r_wait = 2;
        blk_row = 31;
        do_spawn();
        chk("spawn_active", int'(active), 1);
        for (int k = 0; k < 3; k++) begin
            tick_wait(hi);
            chk("req_len", hi, 3);
        end
        chk("row_after_3", int'(row), 3);
        chk("no_lock_3", lock_seen, 0);

        // lock delay at row 7
        r_wait = 0;
        for (int k = 0; k < 4; k++) tick_wait(hi);
        chk("row_7", int'(row), 7);
        blk_row = 7;
        tick_wait(hi);
        chk("lockwait_no_lock", lock_seen, 0);
        chk("lockwait_active", int'(active), 1);
        tick_wait(hi);
        chk("lock_pulse", lock_seen, 1);
        chk("lock_row", int'(row), 7);
        cyc();
        chk("after_lock_active", int'(active), 0);

        // slide off a ledge clears the strike count
        blk_row = 31;
        do_spawn();
        for (int k = 0; k < 7; k++) tick_wait(hi);
        blk_row = 7;
        tick_wait(hi);
        blk_row = 31;
        tick_wait(hi);
        chk("slide_row", int'(row), 8);
        chk("slide_no_lock", lock_seen, 1);
        blk_row = 8;
        tick_wait(hi);
        chk("slide_strike1", lock_seen, 1);
        chk("slide_strike1_active", int'(active), 1);
        tick_wait(hi);
        cyc();
        chk("slide_lock", lock_seen, 2);

        // hard drop from row 2 to a blocked row 10
        blk_row = 31;
        do_spawn();
        tick_wait(hi);
        tick_wait(hi);
        chk("hd_start_row", int'(row), 2);
        blk_row = 10;
        base = lock_seen;
        lat = 0;
        hard_drop = 1;
        for (int i = 0; i < 60; i++) begin
            cyc();
            lat++;
            if (lock_seen > base) break;
        end
        chk("hd_latency", lat, 18);
        chk("hd_row", int'(row), 10);
        cyc();
        chk("hd_single_lock", lock_seen, base + 1);
        chk("hd_idle", int'(active), 0);

        // floor: no request at MAX_ROW, lock on second tick
        blk_row = 31;
        do_spawn();
        for (int k = 0; k < MAX_ROW; k++) tick_wait(hi);
        chk("floor_row", int'(row), 19);
        rises0 = req_rises;
        base = lock_seen;
        tick_wait(hi);
        chk("floor_no_req", req_rises, rises0);
        chk("floor_no_lock", lock_seen, base);
        chk("floor_active", int'(active), 1);
        tick_wait(hi);
        chk("floor_lock", lock_seen, base + 1);
        chk("floor_row_held", int'(row), 19);
        cyc();

        // pause, ack while paused, tick during check
        do_spawn();
        en = 0;
        rises0 = req_rises;
        for (int k = 0; k < 3; k++) tick_wait(hi);
        chk("pause_no_req", req_rises, rises0);
        chk("pause_row", int'(row), 0);
        en = 1;
        r_wait = 3;
        tick_n = 0;
        cyc();
        en = 0;
        for (int i = 0; i < 40 && chk_req; i++) cyc();
        chk("pause_ack_row", int'(row), 1);
        en = 1;
        rises0 = req_rises;
        tick_n = 0;
        cyc();
        tick_n = 0;
        cyc();
        for (int i = 0; i < 40 && chk_req; i++) cyc();
        for (int i = 0; i < 5; i++) cyc();
        chk("tick_in_check_rises", req_rises, rises0 + 1);
        chk("tick_in_check_row", int'(row), 2);

        // reset with an outstanding request
        r_wait = 100;
        tick_n = 0;
        cyc();
        cyc();
        chk("midcheck_req", int'(chk_req), 1);
        rst = 1;
        cyc();
        chk("midrst_req", int'(chk_req), 0);
        chk("midrst_active", int'(active), 0);
        chk("midrst_row", int'(row), 0);
        rst = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
